// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding, halt word, word geometry.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_e;

    localparam int NBITS_DEFAULT = 32;
    // Also used by the instruction memory's halt detection, so both sides agree on the encoding.
    localparam logic [NBITS_DEFAULT-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int BYTES_PER_WORD = NBITS_DEFAULT / 8;

    function automatic int bytes_per_word(input int nbits);
        return nbits / 8;
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word shift register. word_o/word_done_o already include the byte
// being strobed this cycle, so the caller can register the finished word on the same edge.
module byte_assembler
    import loader_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             byte_vld_i,
    input  logic [7:0]       byte_i,
    output logic [NBITS-1:0] word_o,
    output logic             word_done_o
);

    localparam int BPW = bytes_per_word(NBITS);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST = CW'(BPW - 1);

    logic [NBITS-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign word_o      = (shift_q << 8) | NBITS'(byte_i);
    assign word_done_o = byte_vld_i && (cnt_q == LAST);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_vld_i) begin
            shift_d = word_o;
            cnt_d   = word_done_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a UART byte stream into instruction memory from address 0 until the HALT word,
// raising an error if the last address is written without seeing HALT.
module imem_loader
    import loader_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEFAULT)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [NBITS-1:0]      o_wr_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH:0]   o_word_count
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_en_q;
    logic [NBITS-1:0]      wr_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [ADDR_WIDTH:0]   wcnt_q;

    logic             rx_take;
    logic             start_take;
    logic [NBITS-1:0] asm_word;
    logic             asm_done;

    // Bytes arriving in the WRITE cycle belong to the next word, so they are taken there too.
    assign rx_take    = i_rx_valid && (state_q == ST_RECV || state_q == ST_WRITE);
    assign start_take = i_start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);

    byte_assembler #(
        .NBITS (NBITS)
    ) u_asm (
        .clk_i       (i_clk),
        .rst_i       (i_reset),
        .clear_i     (start_take),
        .byte_vld_i  (rx_take),
        .byte_i      (i_rx_data),
        .word_o      (asm_word),
        .word_done_o (asm_done)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            wcnt_q    <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (i_start) begin
                        state_q <= ST_RECV;
                        addr_q  <= '0;
                        wcnt_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (asm_done) begin
                        state_q   <= ST_WRITE;
                        wr_en_q   <= 1'b1;
                        wr_data_q <= asm_word;
                    end
                end
                ST_WRITE: begin
                    wcnt_q <= wcnt_q + 1'b1;
                    if (wr_data_q == HALT_WORD) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (addr_q == ADDR_MAX) begin
                        state_q <= ST_ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                        // Only reachable with single-byte words: the next word completes in this cycle.
                        if (asm_done) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= asm_word;
                        end else begin
                            state_q <= ST_RECV;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_error      = error_q;
    assign o_word_count = wcnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Drives two loaders (256-word and 4-word memories) with the same byte stream and scoreboards their writes.
module tb_imem_loader;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic i_reset = 1'b1;
    logic i_start = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic i_rx_valid = 1'b0;

    logic        a_wr_en, a_busy, a_done, a_error;
    logic [7:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [8:0]  a_wc;
    logic        b_wr_en, b_busy, b_done, b_error;
    logic [1:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [2:0]  b_wc;

    imem_loader #(.NBITS(32), .ADDR_WIDTH(8)) dut_a (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr), .o_wr_data(a_wr_data),
        .o_busy(a_busy), .o_done(a_done), .o_error(a_error), .o_word_count(a_wc)
    );

    imem_loader #(.NBITS(32), .ADDR_WIDTH(2)) dut_b (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data),
        .o_busy(b_busy), .o_done(b_done), .o_error(b_error), .o_word_count(b_wc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[2][$];
    int          depth[2] = '{256, 4};
    bit          active[2];
    int          nb[2];
    logic [31:0] acc[2];
    int          mcnt[2];
    bit          edone[2];
    bit          eerr[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference model: words are consecutive groups of 4 bytes after a start; the load ends
    // at the first HALT word or once every address has been written.
    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (active[d]) begin
                acc[d] = {acc[d][23:0], b};
                nb[d]++;
                if (nb[d] == 4) begin
                    nb[d] = 0;
                    e.addr = mcnt[d];
                    e.data = acc[d];
                    e.cyc  = cyc + 1;
                    q[d].push_back(e);
                    mcnt[d]++;
                    if (acc[d] == HALT) begin
                        active[d] = 1'b0;
                        edone[d]  = 1'b1;
                    end else if (mcnt[d] == depth[d]) begin
                        active[d] = 1'b0;
                        eerr[d]   = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic model_clear(input bit act);
        for (int d = 0; d < 2; d++) begin
            active[d] = act;
            nb[d]     = 0;
            mcnt[d]   = 0;
            edone[d]  = 1'b0;
            eerr[d]   = 1'b0;
        end
    endtask

    task automatic mon(input int d, input int addr, input logic [31:0] data);
        exp_t e;
        if (q[d].size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_write dut%0d: got addr %0d data %h at cycle %0d, required no write", d, addr, data, cyc);
        end else begin
            e = q[d].pop_front();
            chk($sformatf("wr_addr dut%0d", d), 64'(addr), 64'(e.addr));
            chk($sformatf("wr_data dut%0d", d), 64'(data), 64'(e.data));
            chk($sformatf("wr_cycle dut%0d", d), 64'(cyc), 64'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (a_wr_en) mon(0, int'(a_wr_addr), a_wr_data);
        if (b_wr_en) mon(1, int'(b_wr_addr), b_wr_data);
    end

    task automatic drive(input logic [7:0] b);
        @(posedge clk);
        #1;
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        model_byte(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            i_rx_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int i = 3; i >= 0; i--) begin
            drive(w[i*8 +: 8]);
            idle(gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
        end
    endtask

    task automatic start(input bit with_byte, input logic [7:0] b);
        @(posedge clk);
        #1;
        i_start    = 1'b1;
        i_rx_valid = with_byte;
        i_rx_data  = b;
        model_clear(1'b1);
        @(posedge clk);
        #1;
        i_start    = 1'b0;
        i_rx_valid = 1'b0;
        chk("busy_after_start a", 64'(a_busy), 64'd1);
        chk("busy_after_start b", 64'(b_busy), 64'd1);
        chk("done_after_start a", 64'(a_done), 64'd0);
        chk("error_after_start b", 64'(b_error), 64'd0);
        chk("wc_after_start a", 64'(a_wc), 64'd0);
        chk("wc_after_start b", 64'(b_wc), 64'd0);
    endtask

    task automatic check_end(input string tag);
        idle(3);
        chk({tag, " pending a"}, 64'(q[0].size()), 64'd0);
        chk({tag, " pending b"}, 64'(q[1].size()), 64'd0);
        chk({tag, " done a"}, 64'(a_done), 64'(edone[0]));
        chk({tag, " done b"}, 64'(b_done), 64'(edone[1]));
        chk({tag, " error a"}, 64'(a_error), 64'(eerr[0]));
        chk({tag, " error b"}, 64'(b_error), 64'(eerr[1]));
        chk({tag, " wc a"}, 64'(a_wc), 64'(mcnt[0]));
        chk({tag, " wc b"}, 64'(b_wc), 64'(mcnt[1]));
        chk({tag, " busy a"}, 64'(a_busy), 64'(active[0]));
        chk({tag, " busy b"}, 64'(b_busy), 64'(active[1]));
        q[0].delete();
        q[1].delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " wr_en a"}, 64'(a_wr_en), 64'd0);
        chk({tag, " wr_addr a"}, 64'(a_wr_addr), 64'd0);
        chk({tag, " wr_data a"}, 64'(a_wr_data), 64'd0);
        chk({tag, " busy a"}, 64'(a_busy), 64'd0);
        chk({tag, " done a"}, 64'(a_done), 64'd0);
        chk({tag, " error a"}, 64'(a_error), 64'd0);
        chk({tag, " wc a"}, 64'(a_wc), 64'd0);
        chk({tag, " wr_en b"}, 64'(b_wr_en), 64'd0);
        chk({tag, " wr_addr b"}, 64'(b_wr_addr), 64'd0);
        chk({tag, " busy b"}, 64'(b_busy), 64'd0);
        chk({tag, " done b"}, 64'(b_done), 64'd0);
        chk({tag, " error b"}, 64'(b_error), 64'd0);
        chk({tag, " wc b"}, 64'(b_wc), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        i_reset    = 1'b1;
        i_rx_valid = 1'b0;
        i_start    = 1'b0;
        #1;
        chk_all_zero("async_reset");
        model_clear(1'b0);
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear(1'b0);
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        i_reset = 1'b0;

        // Basic three-word load ending in HALT.
        start(1'b0, 8'h00);
        send_word(32'h2001_0005, 0);
        send_word(32'h0000_0000, 0);
        send_word(HALT, 0);
        check_end("basic");

        // Restart from DONE.
        start(1'b0, 8'h00);
        send_word(32'hCAFE_BABE, 1);
        send_word(HALT, 1);
        check_end("restart");

        // Byte arriving in the WRITE cycle starts the next word.
        start(1'b0, 8'h00);
        for (int i = 1; i <= 8; i++) drive(8'(i));
        idle(1);
        send_word(HALT, 0);
        check_end("write_cycle_byte");

        // Five non-HALT words: the 4-word memory fills and errors, the larger one keeps going.
        start(1'b0, 8'h00);
        for (int i = 1; i <= 5; i++) send_word({4{4'(i), 4'(i)}}, 1);
        send_word(HALT, 0);
        drive(8'h77);
        idle(1);
        check_end("overflow");

        // Bytes before start and in the start cycle are discarded.
        do_reset();
        drive(8'hAA);
        drive(8'hBB);
        idle(1);
        start(1'b1, 8'h99);
        send_word(32'h1234_5678, 0);
        send_word(HALT, 0);
        check_end("pre_start_bytes");

        // Reset in the middle of a word, then a clean load.
        start(1'b0, 8'h00);
        drive(8'h11);
        drive(8'h22);
        do_reset();
        start(1'b0, 8'h00);
        send_word(32'hDEAD_0001, 0);
        send_word(HALT, 0);
        check_end("mid_reset");

        for (int l = 0; l < 8; l++) begin
            int nw;
            start($urandom_range(0, 1) == 1, 8'($urandom));
            nw = $urandom_range(0, 6);
            for (int w = 0; w < nw; w++) send_word($urandom, 2);
            send_word(HALT, 2);
            for (int x = 0; x < int'($urandom_range(0, 3)); x++) drive(8'($urandom));
            idle(1);
            check_end($sformatf("random%0d", l));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
